// File: rtl/rv_cpu_core.sv
// rtl/rv_cpu_core.sv - RV32I five-stage in-order pipeline with local instruction/data memories
module rv_cpu_core #(
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_BYTES = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input logic clk,
    input logic rst
);
    localparam int          IA  = $clog2(IMEM_WORDS);
    localparam int          DA  = $clog2(DMEM_BYTES);
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_LD    = 7'h03;
    localparam logic [6:0] OP_ST    = 7'h23;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_OP    = 7'h33;

    logic [31:0] imem [0:IMEM_WORDS-1];
    logic [7:0]  dmem [0:DMEM_BYTES-1];
    logic [31:0] rf_q [0:31];

    logic [31:0] pc_q;
    logic        f_valid_q, x_valid_q, m_valid_q, w_valid_q;
    logic [31:0] f_pc_q, f_instr_q;
    logic [31:0] x_pc_q, x_instr_q, x_rs1v_q, x_rs2v_q;
    logic [31:0] m_instr_q, m_result_q, m_sdata_q;
    logic [31:0] w_instr_q, w_result_q, w_rdata_q;

    function automatic logic writes_rd(input logic [31:0] ins);
        case (ins[6:0])
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LD, OP_IMM, OP_OP: return ins[11:7] != 5'd0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [31:0] ins);
        case (ins[6:0])
            OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_OP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [31:0] ins);
        return (ins[6:0] == OP_BR) || (ins[6:0] == OP_ST) || (ins[6:0] == OP_OP);
    endfunction

    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction
    function automatic logic [31:0] imm_s(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:25], ins[11:7]};
    endfunction
    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction
    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction
    function automatic logic [31:0] imm_u(input logic [31:0] ins);
        return {ins[31:12], 12'h000};
    endfunction

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b, input logic alt);
        case (f3)
            3'b000:  return alt ? a - b : a + b;
            3'b001:  return a << b[4:0];
            3'b010:  return {31'd0, $signed(a) < $signed(b)};
            3'b011:  return {31'd0, a < b};
            3'b100:  return a ^ b;
            3'b101:  return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    // WB stage: load extension and write-back value
    logic [4:0]  w_rd;
    logic        w_we;
    logic [31:0] w_data, w_shift;
    logic [15:0] w_half;
    logic [31:0] w_load;

    always_comb begin
        w_rd    = w_instr_q[11:7];
        w_we    = w_valid_q && writes_rd(w_instr_q);
        w_shift = w_rdata_q >> {w_result_q[1:0], 3'b000};
        w_half  = w_result_q[1] ? w_rdata_q[31:16] : w_rdata_q[15:0];
        case (w_instr_q[14:12])
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = w_rdata_q;
        endcase
        w_data = (w_instr_q[6:0] == OP_LD) ? w_load : w_result_q;
    end

    // ID stage: async regfile read with same-cycle write-back bypass
    logic [4:0]  id_rs1, id_rs2, x_rd;
    logic [31:0] id_rs1v, id_rs2v;
    logic        stall, if_ready, id_ready;

    always_comb begin
        id_rs1  = f_instr_q[19:15];
        id_rs2  = f_instr_q[24:20];
        x_rd    = x_instr_q[11:7];
        id_rs1v = (id_rs1 == 5'd0) ? 32'd0 : (w_we && w_rd == id_rs1) ? w_data : rf_q[id_rs1];
        id_rs2v = (id_rs2 == 5'd0) ? 32'd0 : (w_we && w_rd == id_rs2) ? w_data : rf_q[id_rs2];
        stall   = f_valid_q && x_valid_q && (x_instr_q[6:0] == OP_LD) && (x_rd != 5'd0) &&
                  ((uses_rs1(f_instr_q) && id_rs1 == x_rd) || (uses_rs2(f_instr_q) && id_rs2 == x_rd));
        id_ready = !stall;
        if_ready = id_ready;
    end

    // EX stage: operand forwarding, ALU, branch resolution
    logic [4:0]  x_rs1, x_rs2, m_rd;
    logic        m_fwd;
    logic [31:0] ex_a, ex_b, ex_result, ex_target;
    logic        ex_taken, redirect;

    always_comb begin
        x_rs1 = x_instr_q[19:15];
        x_rs2 = x_instr_q[24:20];
        m_rd  = m_instr_q[11:7];
        m_fwd = m_valid_q && writes_rd(m_instr_q) && (m_instr_q[6:0] != OP_LD);
        ex_a  = (x_rs1 == 5'd0) ? 32'd0 : (m_fwd && m_rd == x_rs1) ? m_result_q :
                (w_we && w_rd == x_rs1) ? w_data : x_rs1v_q;
        ex_b  = (x_rs2 == 5'd0) ? 32'd0 : (m_fwd && m_rd == x_rs2) ? m_result_q :
                (w_we && w_rd == x_rs2) ? w_data : x_rs2v_q;
        ex_result = 32'd0;
        ex_taken  = 1'b0;
        ex_target = x_pc_q + imm_b(x_instr_q);
        case (x_instr_q[6:0])
            OP_LUI:   ex_result = imm_u(x_instr_q);
            OP_AUIPC: ex_result = x_pc_q + imm_u(x_instr_q);
            OP_JAL: begin
                ex_result = x_pc_q + 32'd4;
                ex_taken  = 1'b1;
                ex_target = x_pc_q + imm_j(x_instr_q);
            end
            OP_JALR: begin
                ex_result = x_pc_q + 32'd4;
                ex_taken  = 1'b1;
                ex_target = (ex_a + imm_i(x_instr_q)) & ~32'd1;
            end
            OP_BR: begin
                case (x_instr_q[14:12])
                    3'b000:  ex_taken = ex_a == ex_b;
                    3'b001:  ex_taken = ex_a != ex_b;
                    3'b100:  ex_taken = $signed(ex_a) < $signed(ex_b);
                    3'b101:  ex_taken = $signed(ex_a) >= $signed(ex_b);
                    3'b110:  ex_taken = ex_a < ex_b;
                    3'b111:  ex_taken = ex_a >= ex_b;
                    default: ex_taken = 1'b0;
                endcase
            end
            OP_LD:  ex_result = ex_a + imm_i(x_instr_q);
            OP_ST:  ex_result = ex_a + imm_s(x_instr_q);
            OP_IMM: ex_result = alu(x_instr_q[14:12], ex_a, imm_i(x_instr_q),
                                    (x_instr_q[14:12] == 3'b101) && x_instr_q[30]);
            OP_OP:  ex_result = alu(x_instr_q[14:12], ex_a, ex_b, x_instr_q[30]);
            default: ex_result = 32'd0;
        endcase
        redirect = x_valid_q && ex_taken;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            f_valid_q <= 1'b0;
            f_pc_q    <= RESET_PC;
            f_instr_q <= NOP;
            x_valid_q <= 1'b0;
            x_instr_q <= NOP;
            m_valid_q <= 1'b0;
            m_instr_q <= NOP;
            w_valid_q <= 1'b0;
            w_instr_q <= NOP;
        end else begin
            if (redirect) begin
                pc_q      <= ex_target;
                f_valid_q <= 1'b0;
                f_instr_q <= NOP;
            end else if (if_ready) begin
                pc_q      <= pc_q + 32'd4;
                f_valid_q <= 1'b1;
                f_pc_q    <= pc_q;
                f_instr_q <= imem[pc_q[IA+1:2]];
            end

            if (redirect || !id_ready) begin
                x_valid_q <= 1'b0;
                x_instr_q <= NOP;
            end else begin
                x_valid_q <= f_valid_q;
                x_instr_q <= f_instr_q;
                x_pc_q    <= f_pc_q;
                x_rs1v_q  <= id_rs1v;
                x_rs2v_q  <= id_rs2v;
            end

            m_valid_q  <= x_valid_q;
            m_instr_q  <= x_valid_q ? x_instr_q : NOP;
            m_result_q <= ex_result;
            m_sdata_q  <= ex_b;

            w_valid_q  <= m_valid_q;
            w_instr_q  <= m_instr_q;
            w_result_q <= m_result_q;
        end
    end

    // Data memory is never reset so a preloaded image survives a mid-run reset
    logic [DA-1:0] m_addr;
    assign m_addr = m_result_q[DA-1:0];

    always_ff @(posedge clk) begin
        if (rst && m_valid_q && m_instr_q[6:0] == OP_ST) begin
            case (m_instr_q[13:12])
                2'b00: dmem[m_addr] <= m_sdata_q[7:0];
                2'b01: begin
                    dmem[{m_addr[DA-1:1], 1'b0}] <= m_sdata_q[7:0];
                    dmem[{m_addr[DA-1:1], 1'b1}] <= m_sdata_q[15:8];
                end
                default: begin
                    dmem[{m_addr[DA-1:2], 2'b00}] <= m_sdata_q[7:0];
                    dmem[{m_addr[DA-1:2], 2'b01}] <= m_sdata_q[15:8];
                    dmem[{m_addr[DA-1:2], 2'b10}] <= m_sdata_q[23:16];
                    dmem[{m_addr[DA-1:2], 2'b11}] <= m_sdata_q[31:24];
                end
            endcase
        end
        w_rdata_q <= {dmem[{m_addr[DA-1:2], 2'b11}], dmem[{m_addr[DA-1:2], 2'b10}],
                      dmem[{m_addr[DA-1:2], 2'b01}], dmem[{m_addr[DA-1:2], 2'b00}]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (w_we) begin
            rf_q[w_rd] <= w_data;
        end
    end
endmodule

// File: tb/tb_rv_cpu_core.sv
// tb/tb_rv_cpu_core.sv - directed program bench for rv_cpu_core, observed hierarchically
module tb_rv_cpu_core;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rv_cpu_core dut (
        .clk(clk),
        .rst(rst)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          rd;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_i(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(logic [31:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction
    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] addi(logic [4:0] rd, logic [4:0] rs1, logic [31:0] imm);
        return enc_i(imm, rs1, 3'd0, rd, 7'h13);
    endfunction

    task automatic fill_nops();
        for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0000_0013;
    endtask

    initial begin
        fill_nops();
        for (int i = 0; i < 1024; i++) dut.dmem[i] = 8'h00;
        dut.imem[0]  = addi(1, 0, 5);
        dut.imem[1]  = addi(2, 1, 3);
        dut.imem[2]  = enc_r(7'h00, 2, 1, 3'd0, 3);
        dut.imem[3]  = enc_s(0, 3, 0, 3'd2);
        dut.imem[4]  = enc_i(0, 0, 3'd2, 4, 7'h03);
        dut.imem[5]  = addi(5, 4, 1);
        dut.imem[6]  = addi(6, 0, -128);
        dut.imem[8]  = enc_j(8, 1);
        dut.imem[9]  = enc_j(8, 10);
        dut.imem[10] = enc_i(0, 1, 3'd0, 0, 7'h67);
        dut.imem[11] = enc_s(4, 6, 0, 3'd0);
        dut.imem[12] = enc_i(4, 0, 3'd0, 7, 7'h03);
        dut.imem[13] = enc_i(4, 0, 3'd4, 8, 7'h03);
        dut.imem[14] = enc_b(12, 0, 0, 3'd0);
        dut.imem[15] = addi(9, 9, 1);
        dut.imem[16] = addi(9, 9, 1);
        dut.imem[17] = addi(11, 0, 1);
        dut.imem[18] = enc_i(32'h404, 6, 3'd5, 12, 7'h13);
        dut.imem[19] = enc_i(28, 6, 3'd5, 13, 7'h13);
        dut.imem[20] = enc_r(7'h00, 0, 6, 3'd2, 14);
        dut.imem[21] = enc_r(7'h00, 0, 6, 3'd3, 15);
        dut.imem[22] = enc_r(7'h20, 5, 0, 3'd0, 16);
        dut.imem[23] = enc_i(5, 0, 3'd1, 17, 7'h03);
        dut.imem[24] = enc_b(8, 0, 0, 3'd1);
        dut.imem[25] = addi(18, 0, 3);
        dut.imem[26] = {20'h00001, 5'd19, 7'h17};
        dut.imem[27] = enc_j(0, 0);

        vecs[0]  = '{"x0_zero", 0, 32'h0};
        vecs[1]  = '{"x1_jal_link", 1, 32'h24};
        vecs[2]  = '{"x2_fwd_ma", 2, 32'd8};
        vecs[3]  = '{"x3_add", 3, 32'd13};
        vecs[4]  = '{"x4_lw", 4, 32'd13};
        vecs[5]  = '{"x5_load_use", 5, 32'd14};
        vecs[6]  = '{"x6_neg_imm", 6, 32'hFFFF_FF80};
        vecs[7]  = '{"x7_lb_sext", 7, 32'hFFFF_FF80};
        vecs[8]  = '{"x8_lbu", 8, 32'h80};
        vecs[9]  = '{"x9_squashed", 9, 32'h0};
        vecs[10] = '{"x10_resume_0x24", 10, 32'h28};
        vecs[11] = '{"x11_branch_target", 11, 32'd1};
        vecs[12] = '{"x12_srai", 12, 32'hFFFF_FFF8};
        vecs[13] = '{"x13_srli", 13, 32'hF};
        vecs[14] = '{"x14_slt", 14, 32'd1};
        vecs[15] = '{"x15_sltu", 15, 32'd0};
        vecs[16] = '{"x16_sub", 16, 32'hFFFF_FFF2};
        vecs[17] = '{"x17_lh_misaligned", 17, 32'h80};
        vecs[18] = '{"x18_bne_not_taken", 18, 32'd3};
        vecs[19] = '{"x19_auipc", 19, 32'h1068};

        step();
        step();
        check("reset_pc", dut.pc_q, 32'h0);
        check("reset_x1", dut.rf_q[1], 32'h0);
        check("reset_x31", dut.rf_q[31], 32'h0);
        rst = 1'b1;

        for (int c = 1; c <= 80; c++) begin
            step();
            if (c <= 6) check($sformatf("pc_cycle%0d", c), dut.pc_q, 32'(4 * c));
            if (c == 6) check("x3_before_wb", dut.rf_q[3], 32'h0);
            if (c == 7) begin
                check("pc_held_by_stall", dut.pc_q, 32'h18);
                check("x3_no_stall_timing", dut.rf_q[3], 32'd13);
            end
            if (c == 8) check("pc_after_stall", dut.pc_q, 32'h1C);
            if (c == 10) check("x5_before_wb", dut.rf_q[5], 32'h0);
            if (c == 11) check("x5_one_stall_timing", dut.rf_q[5], 32'd14);
        end

        foreach (vecs[i]) check(vecs[i].name, dut.rf_q[vecs[i].rd], vecs[i].exp);
        check("dmem_word0", {dut.dmem[3], dut.dmem[2], dut.dmem[1], dut.dmem[0]}, 32'd13);
        check("dmem_sb_byte4", {24'd0, dut.dmem[4]}, 32'h80);
        check("dmem_sb_byte5", {24'd0, dut.dmem[5]}, 32'h00);

        // Mid-run reset with a NOP image: pipe flushed, registers cleared, data kept
        rst = 1'b0;
        fill_nops();
        repeat (5) step();
        check("midreset_pc", dut.pc_q, 32'h0);
        for (int r = 1; r < 32; r++) check($sformatf("midreset_x%0d", r), dut.rf_q[r], 32'h0);
        check("midreset_dmem_kept", {24'd0, dut.dmem[0]}, 32'd13);
        rst = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("nop_pc_cycle%0d", c), dut.pc_q, 32'(4 * c));
        end

        // Taken branch at PC 0: target lands in PC two cycles after fetch of the branch
        rst = 1'b0;
        dut.imem[0] = enc_b(16, 0, 0, 3'd0);
        dut.imem[1] = addi(9, 9, 1);
        dut.imem[2] = addi(9, 9, 1);
        dut.imem[3] = addi(9, 9, 1);
        dut.imem[4] = addi(20, 0, 1);
        dut.imem[5] = enc_j(0, 0);
        step();
        step();
        rst = 1'b1;
        step();
        check("br_pc_cycle1", dut.pc_q, 32'h4);
        step();
        check("br_pc_cycle2", dut.pc_q, 32'h8);
        step();
        check("br_pc_redirect", dut.pc_q, 32'h10);
        step();
        check("br_pc_after_target", dut.pc_q, 32'h14);
        repeat (15) step();
        check("br_x9_squashed", dut.rf_q[9], 32'h0);
        check("br_x20_target_ran", dut.rf_q[20], 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
